// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Control FSM that steps an RV32I datapath through FETCH -> DECODE -> EXEC ->
// WB instead of evaluating each instruction in one long combinational cycle.
// It owns the program counter and the instruction register, and handshakes
// with instruction memory. It also gates the regfile write enable so that
// writes happen in WB only. Traps (fetch timeout, illegal opcode, misaligned
// branch target) park the machine in a sticky ERROR state that only reset
// leaves.
//
// Parameters
//   RESET_PC       PC value loaded on reset
//   FETCH_TIMEOUT  cycles imem_req may wait unacknowledged before ERROR (1..255)
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   start          level; moves IDLE or HALT into FETCH
//   halt_req       level; sampled in WB, stops after that instruction retires
//   imem_req       fetch request, held until imem_ack
//   imem_addr      fetch address (always equals pc)
//   imem_ack       fetch data valid this cycle
//   imem_rdata     fetched instruction word
//   instr          instruction register, drives the decoder
//   dec_w_enable   decoder says the current instruction writes the regfile
//   dec_illegal    decoder flags an unsupported opcode
//   pc_load        datapath requests a non-sequential PC (taken branch/jump)
//   pc_target      next PC when pc_load is high
//   rf_we          gated regfile write enable (WB only)
//   pc             current program counter
//   busy           high in FETCH/DECODE/EXEC/WB
//   halted         high in HALT
//   err            high in ERROR
//   err_code       01 fetch timeout, 10 illegal instr, 11 misaligned target
//   retired        count of instructions completed in WB
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        dec_w_enable,
    input  logic        dec_illegal,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] retired
);

    // State encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    // Error codes
    localparam logic [1:0] E_NONE     = 2'b00;
    localparam logic [1:0] E_TIMEOUT  = 2'b01;
    localparam logic [1:0] E_ILLEGAL  = 2'b10;
    localparam logic [1:0] E_MISALIGN = 2'b11;

    // The wait counter holds the number of unacknowledged FETCH cycles already
    // elapsed, so the last allowed waiting cycle is the one where it reads
    // FETCH_TIMEOUT-1. An ack in that cycle still wins.
    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic [7:0]  r_waitCnt;
    logic [1:0]  r_errCode;

    logic [2:0]  w_nextState;
    logic [1:0]  w_errCodeNext;
    logic        w_fetchTimeout;
    logic        w_targetMisaligned;
    logic [31:0] w_nextPc;

    assign w_fetchTimeout     = (r_waitCnt == TIMEOUT_LAST);
    assign w_targetMisaligned = pc_load && (pc_target[1:0] != 2'b00);

    // Sequential fall-through wraps naturally at 2^32.
    assign w_nextPc = pc_load ? pc_target : (r_pc + 32'd4);

    // Next-state logic. The error code is latched on the same edge that
    // enters ERROR so it always describes the trap that caused it.
    always_comb begin
        w_nextState   = r_state;
        w_errCodeNext = r_errCode;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_nextState = S_DECODE;
                end else if (w_fetchTimeout) begin
                    w_nextState   = S_ERROR;
                    w_errCodeNext = E_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    w_nextState   = S_ERROR;
                    w_errCodeNext = E_ILLEGAL;
                end else begin
                    w_nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                // Catching a bad target here keeps WB from ever committing
                // the write or the PC of the offending instruction.
                if (w_targetMisaligned) begin
                    w_nextState   = S_ERROR;
                    w_errCodeNext = E_MISALIGN;
                end else begin
                    w_nextState = S_WB;
                end
            end
            S_WB: begin
                w_nextState = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    w_nextState = S_FETCH;
                end
            end
            S_ERROR: begin
                w_nextState = S_ERROR;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State and trap code registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_errCode <= E_NONE;
        end else begin
            r_state   <= w_nextState;
            r_errCode <= w_errCodeNext;
        end
    end

    // Fetch wait counter: counts only while a request is outstanding and
    // unacknowledged, and is zero whenever a new fetch begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= 8'd0;
        end else if ((r_state == S_FETCH) && !imem_ack) begin
            r_waitCnt <= r_waitCnt + 8'd1;
        end else begin
            r_waitCnt <= 8'd0;
        end
    end

    // Instruction register: captured on the accepted fetch and held through
    // DECODE/EXEC/WB (and across an illegal-instruction trap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= 32'd0;
        end else if ((r_state == S_FETCH) && imem_ack) begin
            r_instr <= imem_rdata;
        end
    end

    // PC and retired counter commit together in WB, the single point where
    // an instruction is considered complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_retired <= 32'd0;
        end else if (r_state == S_WB) begin
            r_pc      <= w_nextPc;
            r_retired <= r_retired + 32'd1;
        end
    end

    // Output decodes straight from the state register, so reset clears them
    // without waiting for a clock edge.
    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign pc        = r_pc;
    assign retired   = r_retired;
    assign err_code  = r_errCode;
    assign rf_we     = (r_state == S_WB) && dec_w_enable;
    assign busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_EXEC)  || (r_state == S_WB);
    assign halted    = (r_state == S_HALT);
    assign err       = (r_state == S_ERROR);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Bench for multicycle_sequencer. A small instruction memory responder and a
// toy decoder surround the DUT. The toy decoder uses this instruction encoding:
// bit0 illegal, bit1 write-enable, bit2 pc_load, bits[15:8] branch target.
// Stimulus pushes expected fetch addresses and expected write-back records
// into queues; an independent monitor pops and compares whenever the DUT
// performs a fetch handshake or pulses rf_we.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int TIMEOUT = 15;

    localparam int K_HALTED  = 0;
    localparam int K_ERR     = 1;
    localparam int K_RETIRED = 2;
    localparam int K_WB_AT   = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        int          cyc;
    } wbRec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        dec_w_enable;
    logic        dec_illegal;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        rf_we;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] retired;

    logic [31:0] mem [0:63];
    int          ackDelay;
    bit          noAck;
    int          waitCnt;
    int          cycCount;
    int          baseCycle;
    int          testsRun;
    int          testsFailed;

    logic [31:0] fetchQ [$];
    wbRec_t      wbQ [$];

    multicycle_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt_req     (halt_req),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .dec_w_enable (dec_w_enable),
        .dec_illegal  (dec_illegal),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .rf_we        (rf_we),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .err          (err),
        .err_code     (err_code),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycCount = 0;
    always @(posedge clk) cycCount <= cycCount + 1;

    // Instruction encoders for the toy decoder
    function automatic logic [31:0] plainInstr(input int idx);
        return {8'hA5, 8'(idx), 16'h0002};
    endfunction

    function automatic logic [31:0] noWriteInstr(input int idx);
        return {8'hD1, 8'(idx), 16'h0000};
    endfunction

    function automatic logic [31:0] illegalInstr(input int idx);
        return {8'hC3, 8'(idx), 16'h0003};
    endfunction

    function automatic logic [31:0] branchInstr(input int idx, input logic [7:0] tgt);
        return {8'hB7, 8'(idx), tgt, 8'h06};
    endfunction

    task automatic reportFail(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        testsFailed++;
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            reportFail(name, actual, expected);
        end
    endtask

    // Instruction memory responder: acks after ackDelay wait cycles
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        waitCnt    = 0;
        forever begin
            @(negedge clk);
            if (imem_req && !noAck) begin
                if (waitCnt >= ackDelay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr[7:2]];
                    waitCnt    = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 32'hDEAD_BEEF;
                    waitCnt++;
                end
            end else begin
                imem_ack = 1'b0;
                waitCnt  = 0;
            end
        end
    end

    // Toy decoder / branch unit driven from the instruction register
    initial begin
        dec_w_enable = 1'b0;
        dec_illegal  = 1'b0;
        pc_load      = 1'b0;
        pc_target    = 32'd0;
        forever begin
            @(negedge clk);
            dec_illegal  = instr[0];
            dec_w_enable = instr[1];
            pc_load      = instr[2];
            pc_target    = {24'd0, instr[15:8]};
        end
    end

    // Monitor: compares fetch handshakes and write-backs against the queues
    initial begin
        logic [31:0] expAddr;
        wbRec_t      rec;
        forever begin
            @(negedge clk);
            #1;
            if (imem_req && imem_ack) begin
                if (fetchQ.size() == 0) begin
                    testsRun++;
                    reportFail("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    expAddr = fetchQ.pop_front();
                    checkOutput("fetch_addr", imem_addr, expAddr);
                end
            end
            if (rf_we) begin
                if (wbQ.size() == 0) begin
                    testsRun++;
                    reportFail("unexpected_rf_we", pc, 32'hFFFF_FFFF);
                end else begin
                    rec = wbQ.pop_front();
                    checkOutput("wb_pc", pc, rec.pc);
                    checkOutput("wb_retired", retired, rec.ret);
                    if (rec.cyc > 0) begin
                        checkOutput("wb_cycle", 32'(cycCount - baseCycle + 1), 32'(rec.cyc));
                    end
                end
            end
        end
    end

    function automatic bit condMet(input int kind, input logic [31:0] val);
        case (kind)
            K_HALTED:  return halted;
            K_ERR:     return err;
            K_RETIRED: return retired == val;
            K_WB_AT:   return rf_we && (pc == val);
            default:   return 1'b0;
        endcase
    endfunction

    task automatic waitCond(input string what, input int kind, input logic [31:0] val,
                            input int bound, output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        while (!done) begin
            @(negedge clk);
            waited++;
            if (condMet(kind, val)) begin
                done = 1'b1;
            end else if (waited >= bound) begin
                testsRun++;
                reportFail({"timeout_", what}, 32'(waited), 32'(bound));
                done = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] fetchAddr, input bit hasWb,
                                 input logic [31:0] wbRet, input int wbCyc);
        wbRec_t rec;
        fetchQ.push_back(fetchAddr);
        if (hasWb) begin
            rec.pc  = fetchAddr;
            rec.ret = wbRet;
            rec.cyc = wbCyc;
            wbQ.push_back(rec);
        end
    endtask

    task automatic applyReset();
        rst      = 1'b1;
        start    = 1'b0;
        halt_req = 1'b0;
        noAck    = 1'b0;
        ackDelay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fetchQ.delete();
        wbQ.delete();
    endtask

    task automatic startRun();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        baseCycle = cycCount;
    endtask

    task automatic loadPlain();
        for (int i = 0; i < 64; i++) begin
            mem[i] = plainInstr(i);
        end
    endtask

    task automatic checkQueuesDrained(input string tag);
        checkOutput({tag, "_fetchq_left"}, 32'(fetchQ.size()), 32'd0);
        checkOutput({tag, "_wbq_left"}, 32'(wbQ.size()), 32'd0);
    endtask

    initial begin
        int waited;
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        start       = 1'b0;
        halt_req    = 1'b0;
        noAck       = 1'b0;
        ackDelay    = 0;
        baseCycle   = 0;
        loadPlain();

        // Reset values
        applyReset();
        checkOutput("rst_pc", pc, 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        checkOutput("rst_flags", {27'd0, imem_req, rf_we, busy, halted, err}, 32'd0);
        checkOutput("rst_err_code", {30'd0, err_code}, 32'd0);

        // Three zero-wait instructions, then halt
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'(4 * i), 1'b1, 32'(i), 4 * (i + 1));
        end
        startRun();
        checkOutput("seq_busy", {31'd0, busy}, 32'd1);
        waitCond("seq_ret2", K_RETIRED, 32'd2, 20, waited);
        halt_req = 1'b1;
        waitCond("seq_halt", K_HALTED, 32'd0, 20, waited);
        halt_req = 1'b0;
        checkOutput("seq_pc", pc, 32'd12);
        checkOutput("seq_retired", retired, 32'd3);
        checkOutput("seq_halt_flags", {29'd0, busy, halted, err}, 32'b010);
        checkQueuesDrained("seq");

        // Halt during instruction 2, then resume with start and halt_req both high
        applyReset();
        applyStimulus(32'd0, 1'b1, 32'd0, 4);
        applyStimulus(32'd4, 1'b1, 32'd1, 8);
        startRun();
        waitCond("hr_ret1", K_RETIRED, 32'd1, 20, waited);
        halt_req = 1'b1;
        waitCond("hr_halt", K_HALTED, 32'd0, 20, waited);
        checkOutput("hr_pc", pc, 32'd8);
        checkOutput("hr_retired", retired, 32'd2);
        repeat (3) @(negedge clk);
        checkOutput("hr_stays_halted", {31'd0, halted}, 32'd1);
        applyStimulus(32'd8, 1'b1, 32'd2, 4);
        startRun();
        checkOutput("hr_resume_req", {31'd0, imem_req}, 32'd1);
        waitCond("hr_halt2", K_HALTED, 32'd0, 20, waited);
        halt_req = 1'b0;
        checkOutput("hr_resume_pc", pc, 32'd12);
        checkOutput("hr_resume_retired", retired, 32'd3);
        checkQueuesDrained("hr");

        // First fetch acked after 3 wait cycles
        applyReset();
        ackDelay = 3;
        halt_req = 1'b1;
        applyStimulus(32'd0, 1'b1, 32'd0, 7);
        startRun();
        for (int i = 0; i < 4; i++) begin
            checkOutput("dly_req_held", {31'd0, imem_req}, 32'd1);
            checkOutput("dly_addr", imem_addr, 32'd0);
            checkOutput("dly_instr_pre", instr, 32'd0);
            @(negedge clk);
        end
        checkOutput("dly_req_drop", {31'd0, imem_req}, 32'd0);
        checkOutput("dly_instr", instr, plainInstr(0));
        waitCond("dly_halt", K_HALTED, 32'd0, 20, waited);
        halt_req = 1'b0;
        checkOutput("dly_pc", pc, 32'd4);
        checkQueuesDrained("dly");

        // Ack in the last allowed waiting cycle is still accepted
        applyReset();
        ackDelay = TIMEOUT - 1;
        halt_req = 1'b1;
        applyStimulus(32'd0, 1'b1, 32'd0, TIMEOUT + 3);
        startRun();
        waitCond("edge_halt", K_HALTED, 32'd0, 40, waited);
        halt_req = 1'b0;
        checkOutput("edge_no_err", {31'd0, err}, 32'd0);
        checkOutput("edge_pc", pc, 32'd4);
        checkQueuesDrained("edge");

        // Fetch timeout -> sticky ERROR
        applyReset();
        noAck = 1'b1;
        startRun();
        waitCond("to_err", K_ERR, 32'd0, 40, waited);
        checkOutput("to_cycle", 32'(waited + 1), 32'(TIMEOUT + 1));
        checkOutput("to_err_code", {30'd0, err_code}, 32'd1);
        checkOutput("to_req_low", {31'd0, imem_req}, 32'd0);
        noAck = 1'b0;
        startRun();
        repeat (3) @(negedge clk);
        checkOutput("to_sticky", {29'd0, busy, halted, err}, 32'b001);
        checkOutput("to_sticky_req", {31'd0, imem_req}, 32'd0);
        applyReset();
        checkOutput("to_rst_err", {30'd0, err, busy}, 32'd0);
        checkOutput("to_rst_code", {30'd0, err_code}, 32'd0);

        // Taken branch at 0x10 to 0x40; instruction at 0x8 does not write
        mem[2]  = noWriteInstr(2);
        mem[4]  = branchInstr(4, 8'h40);
        applyStimulus(32'h00, 1'b1, 32'd0, 4);
        applyStimulus(32'h04, 1'b1, 32'd1, 8);
        applyStimulus(32'h08, 1'b0, 32'd2, 12);
        applyStimulus(32'h0C, 1'b1, 32'd3, 16);
        applyStimulus(32'h10, 1'b1, 32'd4, 20);
        applyStimulus(32'h40, 1'b1, 32'd5, 24);
        startRun();
        waitCond("br_ret5", K_RETIRED, 32'd5, 40, waited);
        halt_req = 1'b1;
        waitCond("br_halt", K_HALTED, 32'd0, 20, waited);
        halt_req = 1'b0;
        checkOutput("br_pc", pc, 32'h44);
        checkOutput("br_retired", retired, 32'd6);
        checkQueuesDrained("br");

        // Misaligned branch target traps before WB
        applyReset();
        loadPlain();
        mem[4] = branchInstr(4, 8'h42);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'(4 * i), 1'b1, 32'(i), 4 * (i + 1));
        end
        applyStimulus(32'h10, 1'b0, 32'd0, 0);
        startRun();
        waitCond("mis_err", K_ERR, 32'd0, 40, waited);
        checkOutput("mis_err_code", {30'd0, err_code}, 32'd3);
        checkOutput("mis_pc", pc, 32'h10);
        checkOutput("mis_retired", retired, 32'd4);
        checkQueuesDrained("mis");
        applyReset();
        checkOutput("mis_rst_pc", pc, 32'd0);

        // Illegal second instruction
        loadPlain();
        mem[1] = illegalInstr(1);
        applyStimulus(32'h0, 1'b1, 32'd0, 4);
        applyStimulus(32'h4, 1'b0, 32'd0, 0);
        startRun();
        waitCond("ill_err", K_ERR, 32'd0, 20, waited);
        checkOutput("ill_err_code", {30'd0, err_code}, 32'd2);
        checkOutput("ill_retired", retired, 32'd1);
        checkOutput("ill_pc", pc, 32'd4);
        checkOutput("ill_instr", instr, illegalInstr(1));
        checkQueuesDrained("ill");

        // Asynchronous reset while a fetch is waiting
        applyReset();
        loadPlain();
        ackDelay = 5;
        startRun();
        @(negedge clk);
        checkOutput("arf_req_before", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arf_flags", {27'd0, imem_req, rf_we, busy, halted, err}, 32'd0);
        checkOutput("arf_pc", pc, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        ackDelay = 0;

        // Asynchronous reset in the middle of WB
        applyStimulus(32'h0, 1'b1, 32'd0, 4);
        applyStimulus(32'h4, 1'b1, 32'd1, 8);
        startRun();
        waitCond("arw_wb", K_WB_AT, 32'd4, 20, waited);
        #2 rst = 1'b1;
        #1;
        checkOutput("arw_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("arw_retired", retired, 32'd0);
        checkOutput("arw_pc", pc, 32'd0);
        checkOutput("arw_instr", instr, 32'd0);
        checkOutput("arw_flags", {28'd0, imem_req, busy, halted, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkQueuesDrained("arw");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
